// File: rtl/cam_ctrl_pkg.sv
// Shared constants, op codes and FSM state encodings for the CAM command sequencer.
package cam_ctrl_pkg;

  localparam int DEPTH  = 16;
  localparam int KEY_W  = 8;
  localparam int ADDR_W = 4;

  localparam logic [KEY_W-1:0] EMPTY_KEY = 8'hFF;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_SEARCH = 3'd2,
    S_EVAL   = 3'd3,
    S_WRITE  = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  // The sentinel marks empty CAM slots, so it can never be stored as a user key.
  function automatic logic key_illegal(input logic [KEY_W-1:0] key);
    return (key == EMPTY_KEY);
  endfunction

endpackage

// File: rtl/cam_free_finder.sv
// Lowest-zero priority encoder over the entry valid bitmap; picks the next slot to allocate.
module cam_free_finder
  import cam_ctrl_pkg::*;
(
  input  logic [DEPTH-1:0]  valid,
  output logic [ADDR_W-1:0] free_idx,
  output logic              all_full
);

  // Scan from the top down so the lowest free index is the last one assigned.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = ADDR_W'(i);
      end else begin
        free_idx = free_idx;
      end
    end
    all_full = &valid;
  end

endmodule

// File: rtl/cam_ctrl.sv
// Command sequencer for a 16x8 CAM: LOOKUP/INSERT/DELETE/CLEAR with entry allocation.
// Optional LOOKUP hit/miss statistics are enabled by defining CAM_CTRL_STATS_EN.
module cam_ctrl
  import cam_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [KEY_W-1:0]  cmd_key,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              cam_wen,
  output logic              cam_ren,
  output logic [KEY_W-1:0]  cam_din,
  output logic [ADDR_W-1:0] cam_addr,
  input  logic [ADDR_W-1:0] cam_dout,
  input  logic              cam_hit
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [7:0]        stat_hits,
  output logic [7:0]        stat_misses
`endif
);

  state_e              state_r, state_s;
  op_e                 op_r, op_s;
  logic [KEY_W-1:0]    key_r, key_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_s;
  logic [ADDR_W-1:0]   tgt_r, tgt_s;
  logic                clr_r, clr_s;
  logic [DEPTH-1:0]    valid_r, valid_s;
  logic [ADDR_W:0]     occ_s;
  logic                full_s;
  logic                ready_s, wen_s, ren_s;
  logic [KEY_W-1:0]    din_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                rv_s, rh_s, re_s;
  logic [ADDR_W-1:0]   ra_s;
  logic                match_s;
  logic [ADDR_W-1:0]   free_idx_s;
  logic                all_full_s;

  cam_free_finder u_free (
    .valid    (valid_r),
    .free_idx (free_idx_s),
    .all_full (all_full_s)
  );

  // Next-state decode; outputs are computed for the state being entered and registered below.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    key_s   = key_r;
    cnt_s   = cnt_r;
    tgt_s   = tgt_r;
    clr_s   = clr_r;
    valid_s = valid_r;
    occ_s   = occupancy;
    ready_s = 1'b0;
    wen_s   = 1'b0;
    ren_s   = 1'b0;
    din_s   = '0;
    addr_s  = '0;
    rv_s    = 1'b0;
    rh_s    = 1'b0;
    re_s    = 1'b0;
    ra_s    = '0;
    // A stale CAM match on a freed slot must not count as a hit.
    match_s = cam_hit && valid_r[cam_dout];

    case (state_r)
      S_INIT: begin
        if (!cam_wen) begin
          // First cycle out of reset only launches the write of entry 0.
          wen_s  = 1'b1;
          addr_s = cnt_r;
          din_s  = EMPTY_KEY;
        end else if (cnt_r == ADDR_W'(DEPTH - 1)) begin
          cnt_s = '0;
          if (clr_r) begin
            state_s = S_RESP;
            clr_s   = 1'b0;
            rv_s    = 1'b1;
          end else begin
            state_s = S_IDLE;
            ready_s = 1'b1;
          end
        end else begin
          cnt_s  = cnt_r + ADDR_W'(1);
          wen_s  = 1'b1;
          addr_s = cnt_r + ADDR_W'(1);
          din_s  = EMPTY_KEY;
        end
      end

      S_IDLE: begin
        if (cmd_valid) begin
          op_s  = op_e'(cmd_op);
          key_s = cmd_key;
          if (op_e'(cmd_op) == OP_CLEAR) begin
            state_s = S_INIT;
            valid_s = '0;
            occ_s   = '0;
            clr_s   = 1'b1;
            cnt_s   = '0;
            wen_s   = 1'b1;
            addr_s  = '0;
            din_s   = EMPTY_KEY;
          end else if (key_illegal(cmd_key)) begin
            state_s = S_RESP;
            rv_s    = 1'b1;
            re_s    = 1'b1;
          end else begin
            state_s = S_SEARCH;
            ren_s   = 1'b1;
            din_s   = cmd_key;
          end
        end else begin
          ready_s = 1'b1;
        end
      end

      S_SEARCH: begin
        state_s = S_EVAL;
      end

      S_EVAL: begin
        case (op_r)
          OP_LOOKUP: begin
            state_s = S_RESP;
            rv_s    = 1'b1;
            rh_s    = match_s;
            ra_s    = match_s ? cam_dout : '0;
          end
          OP_INSERT: begin
            if (match_s) begin
              state_s = S_RESP;
              rv_s    = 1'b1;
              rh_s    = 1'b1;
              ra_s    = cam_dout;
            end else if (all_full_s) begin
              state_s = S_RESP;
              rv_s    = 1'b1;
              re_s    = 1'b1;
            end else begin
              state_s = S_WRITE;
              tgt_s   = free_idx_s;
              wen_s   = 1'b1;
              addr_s  = free_idx_s;
              din_s   = key_r;
            end
          end
          OP_DELETE: begin
            if (match_s) begin
              state_s = S_WRITE;
              tgt_s   = cam_dout;
              wen_s   = 1'b1;
              addr_s  = cam_dout;
              din_s   = EMPTY_KEY;
            end else begin
              state_s = S_RESP;
              rv_s    = 1'b1;
            end
          end
          default: begin
            state_s = S_IDLE;
            ready_s = 1'b1;
          end
        endcase
      end

      S_WRITE: begin
        state_s = S_RESP;
        rv_s    = 1'b1;
        ra_s    = tgt_r;
        if (op_r == OP_INSERT) begin
          valid_s[tgt_r] = 1'b1;
          occ_s          = occupancy + (ADDR_W + 1)'(1);
          rh_s           = 1'b0;
        end else begin
          valid_s[tgt_r] = 1'b0;
          occ_s          = occupancy - (ADDR_W + 1)'(1);
          rh_s           = 1'b1;
        end
      end

      S_RESP: begin
        state_s = S_IDLE;
        ready_s = 1'b1;
      end

      default: begin
        state_s = S_INIT;
        cnt_s   = '0;
      end
    endcase

    full_s = (occ_s == (ADDR_W + 1)'(DEPTH));
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_INIT;
      op_r      <= OP_LOOKUP;
      key_r     <= '0;
      cnt_r     <= '0;
      tgt_r     <= '0;
      clr_r     <= 1'b0;
      valid_r   <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      cmd_ready <= 1'b0;
      cam_wen   <= 1'b0;
      cam_ren   <= 1'b0;
      cam_din   <= '0;
      cam_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= state_s;
      op_r      <= op_s;
      key_r     <= key_s;
      cnt_r     <= cnt_s;
      tgt_r     <= tgt_s;
      clr_r     <= clr_s;
      valid_r   <= valid_s;
      occupancy <= occ_s;
      full      <= full_s;
      cmd_ready <= ready_s;
      cam_wen   <= wen_s;
      cam_ren   <= ren_s;
      cam_din   <= din_s;
      cam_addr  <= addr_s;
      rsp_valid <= rv_s;
      rsp_hit   <= rh_s;
      rsp_addr  <= ra_s;
      rsp_err   <= re_s;
    end
  end

`ifdef CAM_CTRL_STATS_EN
  // Saturating LOOKUP hit/miss counters, counted as each LOOKUP response is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= 8'd0;
      stat_misses <= 8'd0;
    end else if (state_r == S_IDLE && cmd_valid && op_e'(cmd_op) == OP_CLEAR) begin
      stat_hits   <= 8'd0;
      stat_misses <= 8'd0;
    end else if (rv_s && op_s == OP_LOOKUP) begin
      if (rh_s) begin
        stat_hits   <= (stat_hits == 8'hFF) ? stat_hits : stat_hits + 8'd1;
        stat_misses <= stat_misses;
      end else begin
        stat_hits   <= stat_hits;
        stat_misses <= (stat_misses == 8'hFF) ? stat_misses : stat_misses + 8'd1;
      end
    end else begin
      stat_hits   <= stat_hits;
      stat_misses <= stat_misses;
    end
  end
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// Scoreboard bench for cam_ctrl with a behavioural 16x8 CAM and a reference key table.
module tb_cam_ctrl;
  import cam_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_key;
  logic       rsp_valid, rsp_hit, rsp_err, full;
  logic [3:0] rsp_addr;
  logic [4:0] occupancy;
  logic       cam_wen, cam_ren;
  logic [7:0] cam_din;
  logic [3:0] cam_addr;
  logic [3:0] cam_dout = 4'd0;
  logic       cam_hit  = 1'b0;
`ifdef CAM_CTRL_STATS_EN
  logic [7:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  cam_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .occupancy(occupancy), .full(full),
    .cam_wen(cam_wen), .cam_ren(cam_ren), .cam_din(cam_din), .cam_addr(cam_addr),
    .cam_dout(cam_dout), .cam_hit(cam_hit)
`ifdef CAM_CTRL_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  // Behavioural CAM: registered search result, lowest matching index wins.
  logic [7:0] cam_mem [16];
  initial for (int i = 0; i < 16; i++) cam_mem[i] = 8'(i);
  always @(posedge clk) begin
    if (cam_wen) cam_mem[cam_addr] <= cam_din;
    if (cam_ren) begin
      cam_hit  <= 1'b0;
      cam_dout <= 4'd0;
      for (int i = 15; i >= 0; i--) begin
        if (cam_mem[i] == cam_din) begin
          cam_hit  <= 1'b1;
          cam_dout <= 4'(i);
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference key table
  logic [7:0] m_key [16];
  logic       m_val [16];
  int         m_occ = 0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_val[i] = 1'b0;
      m_key[i] = 8'd0;
    end
    m_occ = 0;
  endtask

  typedef struct {
    int hit; int addr; int err; int lat; int occ; int wens; int waddr; int wdin;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int acc_cyc = 0;
  int wen_cnt = 0;
  int last_waddr = 0;
  int last_wdin = 0;

  task automatic send(input logic [1:0] op, input logic [7:0] key);
    exp_t e;
    int   idx;
    int   f;
    @(negedge clk);
    for (int w = 0; w < 60 && !cmd_ready; w++) @(negedge clk);
    if (!cmd_ready) begin
      check_eq("ready_timeout", 0, 1);
      return;
    end
    e = '{hit: 0, addr: 0, err: 0, lat: 3, occ: 0, wens: 0, waddr: 0, wdin: 0};
    idx = -1;
    for (int i = 0; i < 16; i++) if (m_val[i] && m_key[i] == key) idx = i;
    if (op == 2'b11) begin
      e.lat = 17; e.wens = 16; e.waddr = 15; e.wdin = 255;
      model_clear();
    end else if (key == 8'hFF) begin
      e.err = 1; e.lat = 1;
    end else if (op == 2'b00) begin
      if (idx >= 0) begin e.hit = 1; e.addr = idx; end
    end else if (op == 2'b01) begin
      if (idx >= 0) begin
        e.hit = 1; e.addr = idx;
      end else if (m_occ == 16) begin
        e.err = 1;
      end else begin
        f = -1;
        for (int i = 15; i >= 0; i--) if (!m_val[i]) f = i;
        e.addr = f; e.lat = 4; e.wens = 1; e.waddr = f; e.wdin = int'(key);
        m_val[f] = 1'b1; m_key[f] = key; m_occ++;
      end
    end else begin
      if (idx >= 0) begin
        e.hit = 1; e.addr = idx; e.lat = 4; e.wens = 1; e.waddr = idx; e.wdin = 255;
        m_val[idx] = 1'b0; m_occ--;
      end
    end
    e.occ = m_occ;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_key   = key;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
    wen_cnt   = 0;
    sb.push_back(e);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check_eq("rsp_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] key);
    send(op, key);
    wait_rsp();
  endtask

  task automatic check_sweep();
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
      if (cam_wen) begin
        check_eq("sweep_addr", cam_addr, n);
        check_eq("sweep_din", cam_din, 255);
        n++;
      end
    end
    check_eq("sweep_count", n, 16);
    check_eq("ready_after_sweep", cmd_ready, 1);
    check_eq("occ_after_sweep", occupancy, 0);
  endtask

  // Monitor: count CAM writes and score every response against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cam_wen) begin
        wen_cnt++;
        last_waddr = cam_addr;
        last_wdin  = cam_din;
      end
      if (cam_wen && cam_ren) check_eq("wen_ren_excl", 1, 0);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_rsp", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("rsp_hit", rsp_hit, mon_e.hit);
          check_eq("rsp_addr", rsp_addr, mon_e.addr);
          check_eq("rsp_err", rsp_err, mon_e.err);
          check_eq("latency", cyc - acc_cyc + 1, mon_e.lat);
          check_eq("occupancy", occupancy, mon_e.occ);
          check_eq("full", full, (mon_e.occ == 16) ? 1 : 0);
          check_eq("wen_pulses", wen_cnt, mon_e.wens);
          if (mon_e.wens > 0) begin
            check_eq("wen_addr", last_waddr, mon_e.waddr);
            check_eq("wen_din", last_wdin, mon_e.wdin);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_key = 8'd0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_ready", cmd_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_wen", cam_wen, 0);
    check_eq("rst_occ", occupancy, 0);
    rst = 1'b0;
    check_sweep();

    do_cmd(2'b01, 8'd4);
    do_cmd(2'b01, 8'd8);
    do_cmd(2'b01, 8'd35);
    do_cmd(2'b00, 8'd35);
    do_cmd(2'b01, 8'd8);
    do_cmd(2'b00, 8'd87);
    do_cmd(2'b10, 8'd8);
    do_cmd(2'b01, 8'd45);
    do_cmd(2'b10, 8'd99);
    for (int k = 100; k < 113; k++) do_cmd(2'b01, 8'(k));
    check_eq("full_at_16", full, 1);
    do_cmd(2'b00, 8'd112);
    do_cmd(2'b01, 8'd33);
    do_cmd(2'b00, 8'hFF);
    do_cmd(2'b01, 8'hFF);
    do_cmd(2'b11, 8'd0);
    do_cmd(2'b00, 8'd4);
    do_cmd(2'b01, 8'd200);
    do_cmd(2'b01, 8'd201);

    // Reset while the INSERT write is on the CAM pins.
    send(2'b01, 8'd202);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cam_wen) break;
    end
    check_eq("write_seen", cam_wen, 1);
    check_eq("write_addr_before_rst", cam_addr, 2);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_wen", cam_wen, 0);
    check_eq("midrst_addr", cam_addr, 0);
    check_eq("midrst_ready", cmd_ready, 0);
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    check_eq("midrst_occ", occupancy, 0);
    sb.delete();
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_sweep();
    do_cmd(2'b00, 8'd200);
    do_cmd(2'b01, 8'd7);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
